// File: rtl/bldc_hall_pkg.sv
// Shared types and helpers for the hall-sensor feedback stage.
// Covers hall decoding, sector angle bases and the divider state encoding.
package bldc_hall_pkg;

  localparam int NUM_BITS    = 40;
  localparam int DIV_ITERS   = NUM_BITS;
  // Edges from the divider sampling its numerator to the feedback register update
  localparam int DIV_LATENCY = DIV_ITERS + 1;

  typedef enum logic { DIR_REV = 1'b0, DIR_FWD = 1'b1 } dir_e;

  typedef enum logic [1:0] { ST_IDLE, ST_TRACK, ST_FAULT } trk_state_e;

  typedef enum logic [1:0] { DV_IDLE, DV_RUN, DV_DONE } div_state_e;

  typedef struct packed {
    logic       ok;
    logic [2:0] sector;
  } hall_dec_t;

  function automatic hall_dec_t hall_decode(input logic [2:0] code);
    hall_dec_t d;
    d = '{ok: 1'b1, sector: 3'd0};
    case (code)
      3'b001:  d.sector = 3'd0;
      3'b011:  d.sector = 3'd1;
      3'b010:  d.sector = 3'd2;
      3'b110:  d.sector = 3'd3;
      3'b100:  d.sector = 3'd4;
      3'b101:  d.sector = 3'd5;
      default: d.ok = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic [2:0] next_sector(input logic [2:0] s);
    return (s == 3'd5) ? 3'd0 : s + 3'd1;
  endfunction

  function automatic logic [2:0] prev_sector(input logic [2:0] s);
    return (s == 3'd0) ? 3'd5 : s - 3'd1;
  endfunction

  function automatic logic [15:0] sector_base(input logic [2:0] s, input logic [15:0] step);
    return {13'd0, s} * step;
  endfunction

  // Largest in-sector offset; the last sector is trimmed so the angle never wraps past 65535
  function automatic logic [15:0] sector_span(input logic [2:0] s, input logic [15:0] step);
    logic [16:0] last;
    last = {1'b0, sector_base(s, step)} + {1'b0, step} - 17'd1;
    return (last > 17'h0FFFF) ? (16'hFFFF - sector_base(s, step)) : (step - 16'd1);
  endfunction

endpackage

// File: rtl/serial_divider.sv
// Unsigned restoring shift-subtract divider, one quotient bit per clock.
// Start/done handshake; abort returns it to idle; hold freezes it entirely.
module serial_divider
  import bldc_hall_pkg::*;
#(
  parameter int NUM_W = 40,
  parameter int DEN_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             start,
  input  logic             abort,
  input  logic [NUM_W-1:0] numerator,
  input  logic [DEN_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] quotient
);

  localparam int IW = $clog2(NUM_W);

  div_state_e       state;
  logic [DEN_W:0]   rem;
  logic [DEN_W:0]   trial;
  logic [DEN_W-1:0] dvsr;
  logic [NUM_W-1:0] quo;
  logic [IW-1:0]    iter;

  // Numerator bits shift out of quo into the remainder while quotient bits shift in
  assign trial    = {rem[DEN_W-1:0], quo[NUM_W-1]};
  assign busy     = (state != DV_IDLE);
  assign done     = (state == DV_DONE);
  assign quotient = quo;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= DV_IDLE;
      rem   <= '0;
      dvsr  <= '0;
      quo   <= '0;
      iter  <= '0;
    end else if (!hold) begin
      if (abort) begin
        state <= DV_IDLE;
      end else begin
        case (state)
          DV_IDLE: if (start) begin
            rem   <= '0;
            quo   <= numerator;
            dvsr  <= divisor;
            iter  <= '0;
            state <= DV_RUN;
          end
          DV_RUN: begin
            if (trial >= {1'b0, dvsr}) begin
              rem <= trial - {1'b0, dvsr};
              quo <= {quo[NUM_W-2:0], 1'b1};
            end else begin
              rem <= trial;
              quo <= {quo[NUM_W-2:0], 1'b0};
            end
            iter <= iter + IW'(1);
            if (iter == IW'(NUM_W - 1)) state <= DV_DONE;
          end
          DV_DONE: state <= DV_IDLE;
          default: state <= DV_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/bldc_hall_feedback.sv
// Hall sensors to 16-bit electrical angle: synchronise, debounce, decode sector,
// track direction and sector period, and interpolate the angle inside a sector.
module bldc_hall_feedback
  import bldc_hall_pkg::*;
#(
  parameter int DEBOUNCE    = 4,
  parameter int PERIOD_BITS = 24,
  parameter int SECTOR_STEP = 10923
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   hall_a,
  input  logic                   hall_b,
  input  logic                   hall_c,
  output logic [15:0]            feedback,
  output logic [2:0]             sector,
  output logic                   direction,
  output logic                   valid,
  output logic                   fault,
  output logic                   stalled,
  output logic [PERIOD_BITS-1:0] period
);

  localparam int                     CW    = $clog2(DEBOUNCE + 1);
  localparam logic [15:0]            STEP  = 16'(SECTOR_STEP);
  localparam logic [PERIOD_BITS-1:0] P_MAX = '1;

  logic [2:0]    sync1, sync2, cand, acc_code;
  logic [CW-1:0] stable_cnt, stable_next;
  logic          accept;
  hall_dec_t     dec;

  always_comb begin
    if (sync2 != cand)               stable_next = CW'(1);
    else if (stable_cnt == CW'(DEBOUNCE)) stable_next = stable_cnt;
    else                             stable_next = stable_cnt + CW'(1);
  end

  assign accept = (stable_next == CW'(DEBOUNCE)) && (sync2 != acc_code);
  assign dec    = hall_decode(sync2);

  // NOTE: reset here is synchronous, so it lives inside the clocked branch
  // and only takes effect on a rising edge of clk.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1      <= '0;
      sync2      <= '0;
      cand       <= '0;
      stable_cnt <= '0;
    end else if (enable) begin
      sync1      <= {hall_a, hall_b, hall_c};
      sync2      <= sync1;
      cand       <= sync2;
      stable_cnt <= stable_next;
    end
  end

  trk_state_e             state;
  dir_e                   dir_q, dir_new;
  logic [1:0]             adj_cnt, adj_next;
  logic                   prev_adj, is_fwd, is_rev, adj_now;
  logic [PERIOD_BITS-1:0] elapsed, elapsed_inc;
  logic                   stall_hit;
  logic [15:0]            entry_fb, base_cur, span_cur, frac, interp_fb;
  logic                   div_start, div_abort, div_hold, div_busy, div_done;
  logic [NUM_BITS-1:0]    div_num, div_quot;

  assign direction = dir_q;

  // NOTE: every signal written in always_comb gets a value on all paths
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    is_fwd  = dec.ok && (state == ST_TRACK) && (dec.sector == next_sector(sector));
    is_rev  = dec.ok && (state == ST_TRACK) && (dec.sector == prev_sector(sector));
    adj_now = is_fwd || is_rev;
    dir_new = dir_q;
    if (is_fwd)      dir_new = DIR_FWD;
    else if (is_rev) dir_new = DIR_REV;
    adj_next = 2'd0;
    if (adj_now) adj_next = ((adj_cnt == 2'd0) || (dir_new != dir_q)) ? 2'd1 : 2'd2;
    entry_fb = sector_base(dec.sector, STEP);
    if (dir_new == DIR_REV) entry_fb = entry_fb + sector_span(dec.sector, STEP);
  end

  assign elapsed_inc = (elapsed == P_MAX) ? elapsed : elapsed + PERIOD_BITS'(1);
  assign stall_hit   = !accept && !stalled && (elapsed_inc == P_MAX);

  // Numerator is projected to the edge where the result lands, so feedback is current when written
  assign div_num   = (NUM_BITS'(elapsed) + NUM_BITS'(DIV_LATENCY)) * NUM_BITS'(STEP);
  assign div_start = (state == ST_TRACK) && valid && !stalled && !div_busy;
  assign div_abort = accept || stall_hit;
  assign div_hold  = !enable;

  assign base_cur  = sector_base(sector, STEP);
  assign span_cur  = sector_span(sector, STEP);
  assign frac      = (div_quot > NUM_BITS'(span_cur)) ? span_cur : div_quot[15:0];
  assign interp_fb = (dir_q == DIR_FWD) ? base_cur + frac : base_cur + span_cur - frac;

  serial_divider #(
    .NUM_W (NUM_BITS),
    .DEN_W (PERIOD_BITS)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .hold      (div_hold),
    .start     (div_start),
    .abort     (div_abort),
    .numerator (div_num),
    .divisor   (period),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quot)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      acc_code <= 3'b000;
      feedback <= '0;
      sector   <= '0;
      dir_q    <= DIR_REV;
      valid    <= 1'b0;
      fault    <= 1'b0;
      stalled  <= 1'b1;
      period   <= P_MAX;
      elapsed  <= P_MAX;
      adj_cnt  <= '0;
      prev_adj <= 1'b0;
    end else if (enable) begin
      elapsed <= elapsed_inc;
      if (stall_hit) begin
        stalled <= 1'b1;
        valid   <= 1'b0;
        adj_cnt <= '0;
      end
      if (accept) begin
        acc_code <= sync2;
        if (!dec.ok) begin
          state    <= ST_FAULT;
          fault    <= 1'b1;
          valid    <= 1'b0;
          adj_cnt  <= '0;
          prev_adj <= 1'b0;
        end else if (state == ST_IDLE) begin
          // First code after reset only establishes position; it is not an edge
          state    <= ST_TRACK;
          sector   <= dec.sector;
          feedback <= sector_base(dec.sector, STEP);
        end else begin
          state    <= ST_TRACK;
          fault    <= 1'b0;
          sector   <= dec.sector;
          dir_q    <= dir_new;
          adj_cnt  <= adj_next;
          valid    <= (adj_next == 2'd2);
          prev_adj <= adj_now;
          period   <= (prev_adj && adj_now) ? elapsed : P_MAX;
          // Counting the edge cycle itself makes period equal the edge spacing
          elapsed  <= PERIOD_BITS'(1);
          stalled  <= 1'b0;
          feedback <= entry_fb;
        end
      end else if (div_done && valid && !stalled && !stall_hit) begin
        feedback <= interp_fb;
      end
    end
  end

endmodule

// File: tb/tb_bldc_hall_feedback.sv
// Directed bench for bldc_hall_feedback: a default instance for tracking/fault
// tests and an 8-bit-period instance for the stall test.
module tb_bldc_hall_feedback;

  logic        clk = 1'b0;
  logic        rst_n, enable;
  logic [2:0]  hall1, hall2;
  logic [15:0] fb1, fb2;
  logic [2:0]  sec1, sec2;
  logic        dir1, dir2, val1, val2, flt1, flt2, stl1, stl2;
  logic [23:0] per1;
  logic [7:0]  per2;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          t0, k;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bldc_hall_feedback dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .hall_a(hall1[2]), .hall_b(hall1[1]), .hall_c(hall1[0]),
    .feedback(fb1), .sector(sec1), .direction(dir1), .valid(val1),
    .fault(flt1), .stalled(stl1), .period(per1)
  );

  bldc_hall_feedback #(.PERIOD_BITS(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .hall_a(hall2[2]), .hall_b(hall2[1]), .hall_c(hall2[0]),
    .feedback(fb2), .sector(sec2), .direction(dir2), .valid(val2),
    .fault(flt2), .stalled(stl2), .period(per2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_near(input string tag, input logic [31:0] got, input logic [31:0] exp,
                            input int tol);
    int diff;
    diff = int'(got) - int'(exp);
    check(tag, ((diff >= -tol) && (diff <= tol)) ? exp : got, exp);
  endtask

  // Polls on negedges until the chosen instance reports sector s, bounded
  task automatic wait_sec(input bit which, input logic [2:0] s, input string tag);
    for (int i = 0; i < 50; i++) begin
      if ((which ? sec2 : sec1) == s) break;
      @(negedge clk);
    end
    check(tag, which ? sec2 : sec1, s);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Counts clocks from a sector entry until fb1 changes at or after kmin
  task automatic wait_update(input int kmin, output int kk);
    logic [15:0] prev;
    prev = fb1;
    kk   = 0;
    for (int i = 0; i < kmin + 200; i++) begin
      @(negedge clk);
      kk++;
      if ((kk >= kmin) && (fb1 != prev)) break;
      prev = fb1;
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b1;
    hall1  = 3'b001;
    hall2  = 3'b001;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_sector",  sec1, 0);
    check("rst_fb",      fb1, 0);
    check("rst_valid",   val1, 0);
    check("rst_stalled", stl1, 1);
    check("rst_period",  per1, 24'hFFFFFF);

    // Forward 001 -> 011 -> 010, 1000 clk apart
    t0 = cyc; hall1 = 3'b011;
    wait_sec(0, 3'd1, "fwd_s1");
    check("fwd1_dir",    dir1, 1);
    check("fwd1_valid",  val1, 0);
    check("fwd1_period", per1, 24'hFFFFFF);
    check("fwd1_fb",     fb1, 10923);
    wait_until(t0 + 1000); hall1 = 3'b010;
    wait_sec(0, 3'd2, "fwd_s2");
    check("fwd2_valid",  val1, 1);
    check("fwd2_period", per1, 1000);
    check("fwd2_fb",     fb1, 21846);
    wait_update(500, k);
    check_near("fwd_interp", fb1, 21846 + (k * 10923) / 1000, 2);

    // Reverse 011 -> 001
    wait_until(t0 + 2000); hall1 = 3'b011;
    wait_sec(0, 3'd1, "rev_s1");
    check("rev1_dir",   dir1, 0);
    check("rev1_fb",    fb1, 21845);
    check("rev1_valid", val1, 0);
    wait_until(t0 + 3000); hall1 = 3'b001;
    wait_sec(0, 3'd0, "rev_s0");
    check("rev0_fb",     fb1, 10922);
    check("rev0_valid",  val1, 1);
    check("rev0_period", per1, 1000);
    wait_update(300, k);
    check_near("rev_interp", fb1, 10922 - (k * 10923) / 1000, 2);

    // 3-cycle glitch is shorter than the debounce window
    hall1 = 3'b011;
    repeat (3) @(negedge clk);
    hall1 = 3'b001;
    repeat (20) @(negedge clk);
    check("glitch_sector", sec1, 0);
    check("glitch_dir",    dir1, 0);

    // Skip 001 -> 110
    hall1 = 3'b110;
    wait_sec(0, 3'd3, "jump_s3");
    check("jump_valid",  val1, 0);
    check("jump_period", per1, 24'hFFFFFF);
    check("jump_fb",     fb1, 43691);

    // Invalid code 111, then back to 110
    hall1 = 3'b111;
    for (int i = 0; i < 20 && !flt1; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    check("fault_set",   flt1, 1);
    check("fault_valid", val1, 0);
    check("fault_fb",    fb1, 43691);
    check("fault_sec",   sec1, 3);
    hall1 = 3'b110;
    for (int i = 0; i < 20 && flt1; i++) @(negedge clk);
    check("fault_clr",     flt1, 0);
    check("fault_clr_sec", sec1, 3);
    check("fault_clr_fb",  fb1, 43691);

    // Forward into the last sector and clamp at the top of the angle range
    t0 = cyc; hall1 = 3'b100;
    wait_sec(0, 3'd4, "fwd_s4");
    check("s4_fb",  fb1, 43692);
    check("s4_dir", dir1, 1);
    wait_until(t0 + 1000); hall1 = 3'b101;
    wait_sec(0, 3'd5, "fwd_s5");
    check("s5_fb",     fb1, 54615);
    check("s5_valid",  val1, 1);
    repeat (1100) @(negedge clk);
    check("s5_clamp",  fb1, 65535);

    // Stall on the 8-bit-period instance
    t0 = cyc; hall2 = 3'b011;
    wait_sec(1, 3'd1, "stl_s1");
    wait_until(t0 + 100); hall2 = 3'b010;
    wait_sec(1, 3'd2, "stl_s2");
    check("stl_valid0",  val2, 1);
    check("stl_period",  per2, 100);
    repeat (250) @(negedge clk);
    check("stl_pre",     stl2, 0);
    check("stl_pre_fb",  fb2, 32768);
    repeat (10) @(negedge clk);
    check("stl_set",     stl2, 1);
    check("stl_valid",   val2, 0);
    repeat (40) @(negedge clk);
    check("stl_fb_hold", fb2, 32768);

    // enable=0 freezes the decoder
    enable = 1'b0;
    hall1  = 3'b100;
    repeat (30) @(negedge clk);
    check("dis_sector", sec1, 5);
    check("dis_fb",     fb1, 65535);
    hall1  = 3'b101;
    enable = 1'b1;
    repeat (10) @(negedge clk);

    // Reset while the divider is looping
    rst_n = 1'b0;
    @(negedge clk);
    check("mrst_fb",      fb1, 0);
    check("mrst_sector",  sec1, 0);
    check("mrst_dir",     dir1, 0);
    check("mrst_valid",   val1, 0);
    check("mrst_fault",   flt1, 0);
    check("mrst_stalled", stl1, 1);
    check("mrst_period",  per1, 24'hFFFFFF);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
